bin2bcd_iter: RTL and testbench

Parametrised iterative binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It has valid/ready handshakes on input and output, an optional two's-complement mode, overflow saturation and a leading-zero mask. It sits between binary datapaths (counters, ADC words) and the display/driver logic, and supersedes the fixed load/ready digit-chain converter.

---
 rtl/bin2bcd_iter.sv | 173 +++++++++++++++++
 tb/tb_bin2bcd_iter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: iterative binary-to-BCD converter (shift-and-add-3, one bit per
// clock) with valid/ready handshakes, optional two's-complement input, overflow
// saturation to all nines and a leading-zero digit mask.
module bin2bcd_iter #(
  parameter int N_BITS   = 12,
  parameter int N_DIGITS = 4,
  parameter bit SIGNED   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  neg,
  output logic                  overflow,
  output logic [N_DIGITS-1:0]   lz_mask
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   mag_q, mag_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                sign_q, sign_d;
  logic                nz_q, nz_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovfl_q, ovfl_d;
  logic [N_DIGITS-1:0] lz_q, lz_d;
  logic                vld_q, vld_d;

  logic                accept;
  logic                sign_in;
  logic [N_BITS-1:0]   mag_in;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       acc_sh;

  // Add 3 to every digit that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Bit i set when digit i and every digit above it are zero; digit 0 is
  // always shown, so bit 0 stays clear.
  function automatic logic [N_DIGITS-1:0] lz_of(input logic [BW-1:0] b);
    logic [N_DIGITS-1:0] m;
    logic                z;
    m = '0;
    z = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      z    = z && (b[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Magnitude of the incoming word; the most negative value maps to
  // 2^(N_BITS-1), which still fits in N_BITS unsigned bits.
  assign sign_in = SIGNED && bin[N_BITS-1];
  assign mag_in  = sign_in ? (~bin + {{(N_BITS-1){1'b0}}, 1'b1}) : bin;

  assign adj    = add3(acc_q);
  assign acc_sh = {adj[BW-2:0], mag_q[N_BITS-1]};

  // Next-state logic: conversion step, result capture and handshake control.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    nz_d    = nz_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovfl_d  = ovfl_q;
    lz_d    = lz_q;
    vld_d   = vld_q;

    unique case (state_q)
      IDLE: ;
      CONV: begin
        mag_d = {mag_q[N_BITS-2:0], 1'b0};
        acc_d = acc_sh;
        // A one leaving the top digit means the value no longer fits.
        ovf_d = ovf_q | adj[BW-1];
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          vld_d   = 1'b1;
          bcd_d   = ovf_d ? {N_DIGITS{4'h9}} : acc_sh;
          ovfl_d  = ovf_d;
          neg_d   = sign_q && nz_q;
          lz_d    = lz_of(bcd_d);
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept happens from IDLE or, back-to-back, from DONE on the handshake.
    if (accept) begin
      mag_d   = mag_in;
      sign_d  = sign_in;
      nz_d    = (bin != '0);
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = CW'(N_BITS);
      vld_d   = 1'b0;
      state_d = CONV;
    end
  end

  // State and result registers; reset aborts any conversion and clears outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      nz_q    <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      lz_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      nz_q    <= nz_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovfl_q  <= ovfl_d;
      lz_q    <= lz_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign overflow  = ovfl_q;
  assign lz_mask   = lz_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb_bin2bcd_iter: three converter instances (12b/4 digits unsigned,
// 12b/3 digits unsigned, 8b/4 digits signed) checked against an arithmetic
// decimal reference model.
module tb_bin2bcd_iter;

  localparam int NB[3] = '{12, 12, 8};
  localparam int ND[3] = '{4, 3, 4};
  localparam int SG[3] = '{0, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iv[3];
  logic        ordy[3];
  logic [11:0] bn[3];

  logic        irdy[3];
  logic        ovld[3];
  logic        ngo[3];
  logic        ofo[3];
  logic [15:0] obcd[3];
  logic [3:0]  olz[3];

  logic [15:0] bcd0, bcd2;
  logic [11:0] bcd1;
  logic [3:0]  lz0, lz2;
  logic [2:0]  lz1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    obcd[0] = bcd0;
    obcd[1] = {4'h0, bcd1};
    obcd[2] = bcd2;
    olz[0]  = lz0;
    olz[1]  = {1'b0, lz1};
    olz[2]  = lz2;
  end

  bin2bcd_iter #(.N_BITS(12), .N_DIGITS(4), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .bin(bn[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .bcd(bcd0),
    .neg(ngo[0]), .overflow(ofo[0]), .lz_mask(lz0));

  bin2bcd_iter #(.N_BITS(12), .N_DIGITS(3), .SIGNED(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .bin(bn[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .bcd(bcd1),
    .neg(ngo[1]), .overflow(ofo[1]), .lz_mask(lz1));

  bin2bcd_iter #(.N_BITS(8), .N_DIGITS(4), .SIGNED(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .bin(bn[2][7:0]), .out_valid(ovld[2]), .out_ready(ordy[2]), .bcd(bcd2),
    .neg(ngo[2]), .overflow(ofo[2]), .lz_mask(lz2));

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  // Reference: interpret the word as an integer, take sign and magnitude,
  // clamp to the largest N_DIGITS-digit number, then split into decimal digits.
  function automatic void model(input int k, input logic [11:0] b,
                                output logic [15:0] eb, output logic en,
                                output logic eo, output logic [3:0] el);
    int v, mag, lim, p;
    v = int'(b) & ((1 << NB[k]) - 1);
    if (SG[k] != 0 && v >= (1 << (NB[k] - 1))) v -= (1 << NB[k]);
    en  = (v < 0);
    mag = en ? -v : v;
    lim = pow10(ND[k]) - 1;
    eo  = (mag > lim);
    if (eo) mag = lim;
    eb = '0;
    el = '0;
    p  = 1;
    for (int i = 0; i < ND[k]; i++) begin
      eb[4*i +: 4] = 4'((mag / p) % 10);
      if (i > 0) el[i] = (mag < p);
      p *= 10;
    end
  endfunction

  // Idle -> accept -> wait for result -> check -> handshake.
  task automatic run(input int k, input logic [11:0] b);
    logic [15:0] eb;
    logic        en, eo;
    logic [3:0]  el;
    int          cyc;
    model(k, b, eb, en, eo, el);
    total++;
    if (irdy[k] !== 1'b1) begin bad++; $display("FAIL idle_in_ready[%0d]: got %b want 1", k, irdy[k]); end
    iv[k] = 1'b1; bn[k] = b; ordy[k] = 1'b0;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    cyc = 0;
    while (ovld[k] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    total++;
    if (cyc != NB[k]) begin bad++; $display("FAIL latency[%0d] bin=%h: got %0d want %0d", k, b, cyc, NB[k]); end
    total++;
    if (obcd[k] !== eb) begin bad++; $display("FAIL bcd[%0d] bin=%h: got %h want %h", k, b, obcd[k], eb); end
    total++;
    if (ngo[k] !== en) begin bad++; $display("FAIL neg[%0d] bin=%h: got %b want %b", k, b, ngo[k], en); end
    total++;
    if (ofo[k] !== eo) begin bad++; $display("FAIL overflow[%0d] bin=%h: got %b want %b", k, b, ofo[k], eo); end
    total++;
    if (olz[k] !== el) begin bad++; $display("FAIL lz_mask[%0d] bin=%h: got %b want %b", k, b, olz[k], el); end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    total++;
    if (ovld[k] !== 1'b0) begin bad++; $display("FAIL handshake_drop[%0d]: got %b want 0", k, ovld[k]); end
    total++;
    if (obcd[k] !== eb) begin bad++; $display("FAIL bcd_kept[%0d]: got %h want %h", k, obcd[k], eb); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ovld[k], ngo[k], ofo[k], obcd[k], olz[k]} !== 23'd0) begin
        bad++; $display("FAIL reset_outputs[%0d]: got v=%b bcd=%h n=%b o=%b lz=%b want all 0",
                        k, ovld[k], obcd[k], ngo[k], ofo[k], olz[k]);
      end
      total++;
      if (irdy[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, irdy[k]); end
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run(0, 12'hFFF);
    run(0, 12'd7);
    run(0, 12'd0);
    run(1, 12'd1000);
    run(1, 12'd999);
    run(2, 12'h080);
    run(2, 12'h0FF);
    run(2, 12'h07F);
    run(2, 12'h000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) run(k, 12'($urandom));
    end
  endtask

  task automatic test_ignore_conv();
    logic [15:0] eb;
    logic        en, eo;
    logic [3:0]  el;
    logic [11:0] b;
    int          cyc;
    b = 12'($urandom_range(0, 4095));
    model(0, b, eb, en, eo, el);
    iv[0] = 1'b1; bn[0] = b; ordy[0] = 1'b0;
    @(posedge clk); #1;
    bn[0] = ~b;
    total++;
    if (irdy[0] !== 1'b0) begin bad++; $display("FAIL conv_in_ready: got %b want 0", irdy[0]); end
    cyc = 0;
    while (ovld[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    iv[0] = 1'b0;
    total++;
    if (cyc != 12) begin bad++; $display("FAIL ignore_latency: got %0d want 12", cyc); end
    total++;
    if (obcd[0] !== eb) begin bad++; $display("FAIL ignore_bcd: got %h want %h", obcd[0], eb); end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] eb, eb2;
    logic        en, eo, en2, eo2;
    logic [3:0]  el, el2;
    logic [11:0] b;
    int          cyc;
    b = 12'($urandom_range(1, 4095));
    model(0, b, eb, en, eo, el);
    model(0, 12'd42, eb2, en2, eo2, el2);
    iv[0] = 1'b1; bn[0] = b; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    cyc = 0;
    while (ovld[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (ovld[0] !== 1'b1 || obcd[0] !== eb || ngo[0] !== en || irdy[0] !== 1'b0) begin
        bad++; $display("FAIL backpressure_hold cycle %0d: got v=%b bcd=%h n=%b rdy=%b want v=1 bcd=%h n=%b rdy=0",
                        i, ovld[0], obcd[0], ngo[0], irdy[0], eb, en);
      end
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; bn[0] = 12'd42;
    #1;
    total++;
    if (irdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", irdy[0]); end
    @(posedge clk); #1;
    ordy[0] = 1'b0; iv[0] = 1'b0;
    total++;
    if (ovld[0] !== 1'b0 || obcd[0] !== eb) begin
      bad++; $display("FAIL b2b_accept: got v=%b bcd=%h want v=0 bcd=%h", ovld[0], obcd[0], eb);
    end
    cyc = 0;
    while (ovld[0] !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    total++;
    if (cyc != 12) begin bad++; $display("FAIL b2b_latency: got %0d want 12", cyc); end
    total++;
    if (obcd[0] !== eb2) begin bad++; $display("FAIL b2b_bcd: got %h want %h", obcd[0], eb2); end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    iv[0] = 1'b1; bn[0] = 12'd3071; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ovld[k], ngo[k], ofo[k], obcd[k], olz[k]} !== 23'd0 || irdy[k] !== 1'b1) begin
        bad++; $display("FAIL midconv_reset[%0d]: got v=%b bcd=%h n=%b o=%b lz=%b rdy=%b want zeros rdy=1",
                        k, ovld[k], obcd[k], ngo[k], ofo[k], olz[k], irdy[k]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(0, 12'd255);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; bn[k] = '0;
    end
    test_reset();
    test_directed();
    test_random();
    test_ignore_conv();
    test_back_to_back();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
